// File: rtl/motor_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : motor_pwm_driver
// Purpose  : Two-channel H-bridge driver with 8-step PWM and reversal dead-time.
//            Optional macro MOTOR_RAMP_EN adds a +/-1-per-period power ramp.
// Revision : 1.0 - initial release
// ============================================================================
module motor_pwm_driver #(
   parameter int PRESCALE     = 2500,
   parameter int DEAD_PERIODS = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [4:0] MC1,
   input  logic [4:0] MC2,
   output logic       R_EN,
   output logic       R_INA,
   output logic       R_INB,
   output logic       L_EN,
   output logic       L_INA,
   output logic       L_INB,
   output logic       PERIOD_TICK,
   output logic [1:0] DEAD_ACT
);

   localparam int              c_PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_PW-1:0] c_PRE_LAST   = c_PW'(PRESCALE - 1);
   localparam logic [3:0]      c_DEAD_INIT  = 4'(DEAD_PERIODS);

   typedef enum logic [1:0] {
      ST_NEUTRAL = 2'd0,
      ST_DRIVE   = 2'd1,
      ST_DEAD    = 2'd2
   } state_t;

   logic [c_PW-1:0] r_pre;
   logic [2:0]      r_step;
   logic            w_pre_wrap;
   logic            w_boundary;
   logic [2:0]      w_step_nxt;

   assign w_pre_wrap = (r_pre == c_PRE_LAST);
   assign w_boundary = w_pre_wrap && (r_step == 3'd7);
   assign w_step_nxt = w_pre_wrap ? (r_step + 3'd1) : r_step;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pre  <= '0;
         r_step <= '0;
      end else if (w_pre_wrap) begin
         r_pre  <= '0;
         r_step <= r_step + 3'd1;
      end else begin
         r_pre  <= r_pre + 1'b1;
      end
   end

   assign PERIOD_TICK = w_boundary;

   logic [4:0] w_mc [2];
   assign w_mc[0] = MC1;
   assign w_mc[1] = MC2;

   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      state_t     r_state;
      logic       r_rev;
      logic [2:0] r_code;
      logic [3:0] r_dead;
      logic       r_en;
      logic       r_ina;
      logic       r_inb;

      logic       w_cmd_fwd;
      logic       w_cmd_rev;
      logic       w_cmd_go;
      logic [2:0] w_cmd_code;
      logic [2:0] w_n;
      logic [2:0] w_entry_code;
      logic [2:0] w_next_code;

      assign w_cmd_fwd  = (w_mc[gi][1:0] == 2'b00);
      assign w_cmd_rev  = (w_mc[gi][1:0] == 2'b10);
      assign w_cmd_go   = w_cmd_fwd || w_cmd_rev;
      assign w_cmd_code = w_mc[gi][4:2];
      // Codes 0 and 1 both give a single on-step, so the output never idles in DRIVE.
      assign w_n        = (r_code == 3'd0) ? 3'd1 : r_code;

`ifdef MOTOR_RAMP_EN
      assign w_entry_code = 3'd0;
      assign w_next_code  = (r_code < w_cmd_code) ? (r_code + 3'd1) :
                            (r_code > w_cmd_code) ? (r_code - 3'd1) : r_code;
`else
      assign w_entry_code = w_cmd_code;
      assign w_next_code  = w_cmd_code;
`endif

      // On a boundary the next cycle is step 0, and n>=1, so EN is simply "in DRIVE".
      always_ff @(posedge CLK) begin
         if (RST) begin
            r_state <= ST_NEUTRAL;
            r_rev   <= 1'b0;
            r_code  <= 3'd0;
            r_dead  <= 4'd0;
            r_en    <= 1'b0;
            r_ina   <= 1'b0;
            r_inb   <= 1'b0;
         end else if (w_boundary) begin
            case (r_state)
               ST_NEUTRAL: begin
                  if (w_cmd_go) begin
                     r_state <= ST_DRIVE;
                     r_rev   <= w_cmd_rev;
                     r_code  <= w_entry_code;
                     r_en    <= 1'b1;
                     r_ina   <= w_cmd_fwd;
                     r_inb   <= w_cmd_rev;
                  end else begin
                     r_en    <= 1'b0;
                     r_ina   <= 1'b0;
                     r_inb   <= 1'b0;
                  end
               end
               ST_DRIVE: begin
                  if (!w_cmd_go) begin
                     r_state <= ST_NEUTRAL;
                     r_en    <= 1'b0;
                     r_ina   <= 1'b0;
                     r_inb   <= 1'b0;
                  end else if (w_cmd_rev != r_rev) begin
                     r_state <= ST_DEAD;
                     r_dead  <= c_DEAD_INIT;
                     r_en    <= 1'b0;
                     r_ina   <= 1'b0;
                     r_inb   <= 1'b0;
                  end else begin
                     r_code  <= w_next_code;
                     r_en    <= 1'b1;
                     r_ina   <= !r_rev;
                     r_inb   <= r_rev;
                  end
               end
               ST_DEAD: begin
                  r_dead <= r_dead - 4'd1;
                  if (r_dead == 4'd1 && w_cmd_go) begin
                     r_state <= ST_DRIVE;
                     r_rev   <= w_cmd_rev;
                     r_code  <= w_entry_code;
                     r_en    <= 1'b1;
                     r_ina   <= w_cmd_fwd;
                     r_inb   <= w_cmd_rev;
                  end else begin
                     if (r_dead == 4'd1) begin
                        r_state <= ST_NEUTRAL;
                     end
                     r_en    <= 1'b0;
                     r_ina   <= 1'b0;
                     r_inb   <= 1'b0;
                  end
               end
               default: begin
                  r_state <= ST_NEUTRAL;
                  r_en    <= 1'b0;
                  r_ina   <= 1'b0;
                  r_inb   <= 1'b0;
               end
            endcase
         end else begin
            r_en <= (r_state == ST_DRIVE) && (w_step_nxt < w_n);
         end
      end
   end

   assign R_EN     = g_ch[0].r_en;
   assign R_INA    = g_ch[0].r_ina;
   assign R_INB    = g_ch[0].r_inb;
   assign L_EN     = g_ch[1].r_en;
   assign L_INA    = g_ch[1].r_ina;
   assign L_INB    = g_ch[1].r_inb;
   assign DEAD_ACT = {(g_ch[1].r_state == ST_DEAD), (g_ch[0].r_state == ST_DEAD)};

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_pwm_driver
// Purpose  : Directed and random checks of motor_pwm_driver against a
//            period-level reference model (honours MOTOR_RAMP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_pwm_driver;

   localparam int c_P      = 2;
   localparam int c_DEAD   = 2;
   localparam int c_PERIOD = 8 * c_P;
   localparam int M_NEU = 0, M_DRV = 1, M_DED = 2;

`ifdef MOTOR_RAMP_EN
   localparam int c_FWD4 = 2, c_FWD7 = 10, c_REV7 = 2;
   int ramp_exp [8] = '{2, 2, 4, 6, 8, 10, 12, 12};
`else
   localparam int c_FWD4 = 8, c_FWD7 = 14, c_REV7 = 14;
   int ramp_exp [8] = '{2, 12, 12, 12, 12, 12, 12, 12};
`endif
   int sweep_exp [8] = '{2, 2, 4, 6, 8, 10, 12, 14};

   logic       CLK = 1'b0;
   logic       RST;
   logic [4:0] MC1, MC2;
   logic       R_EN, R_INA, R_INB, L_EN, L_INA, L_INB, PERIOD_TICK;
   logic [1:0] DEAD_ACT;

   motor_pwm_driver #(.PRESCALE(c_P), .DEAD_PERIODS(c_DEAD)) dut (
      .CLK(CLK), .RST(RST), .MC1(MC1), .MC2(MC2),
      .R_EN(R_EN), .R_INA(R_INA), .R_INB(R_INB),
      .L_EN(L_EN), .L_INA(L_INA), .L_INB(L_INB),
      .PERIOD_TICK(PERIOD_TICK), .DEAD_ACT(DEAD_ACT)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int acc_ren, acc_len, acc_dead0;
   int d1, d2;

   // Reference model: position within the period plus per-channel mode.
   int m_pos = 0;
   int m_mode [2];
   bit m_rev  [2];
   int m_duty [2];
   int m_dead [2];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void enter(int i, bit rv, int code);
      m_mode[i] = M_DRV;
      m_rev[i]  = rv;
`ifdef MOTOR_RAMP_EN
      m_duty[i] = 0;
`else
      m_duty[i] = code;
`endif
   endfunction

   function automatic void boundary(int i, logic [4:0] mc);
      int code = int'(mc[4:2]);
      bit fwd  = (mc[1:0] == 2'b00);
      bit rv   = (mc[1:0] == 2'b10);
      case (m_mode[i])
         M_NEU: if (fwd || rv) enter(i, rv, code);
         M_DRV: begin
            if (!(fwd || rv)) m_mode[i] = M_NEU;
            else if (rv != m_rev[i]) begin
               m_mode[i] = M_DED;
               m_dead[i] = c_DEAD;
            end else begin
`ifdef MOTOR_RAMP_EN
               if (code > m_duty[i]) m_duty[i]++;
               else if (code < m_duty[i]) m_duty[i]--;
`else
               m_duty[i] = code;
`endif
            end
         end
         default: begin
            m_dead[i]--;
            if (m_dead[i] == 0) begin
               if (fwd || rv) enter(i, rv, code);
               else m_mode[i] = M_NEU;
            end
         end
      endcase
   endfunction

   function automatic void model_edge();
      if (RST) begin
         m_pos = 0;
         for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_NEU; m_rev[i] = 0; m_duty[i] = 0; m_dead[i] = 0;
         end
      end else begin
         if (m_pos == c_PERIOD - 1) begin
            boundary(0, MC1);
            boundary(1, MC2);
         end
         m_pos = (m_pos + 1) % c_PERIOD;
      end
   endfunction

   function automatic logic [2:0] exp_pins(int i);
      int n = (m_duty[i] == 0) ? 1 : m_duty[i];
      bit drv = (m_mode[i] == M_DRV);
      return {drv && (m_pos < n * c_P), drv && !m_rev[i], drv && m_rev[i]};
   endfunction

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
      check("right_pins", {R_EN, R_INA, R_INB}, exp_pins(0));
      check("left_pins",  {L_EN, L_INA, L_INB}, exp_pins(1));
      check("period_tick", PERIOD_TICK, (m_pos == c_PERIOD - 1));
      check("dead_act", DEAD_ACT, {(m_mode[1] == M_DED), (m_mode[0] == M_DED)});
      check("ab_exclusive", {R_INA & R_INB, L_INA & L_INB}, 2'b00);
      acc_ren   += R_EN;
      acc_len   += L_EN;
      acc_dead0 += DEAD_ACT[0];
   endtask

   task automatic period();
      acc_ren = 0; acc_len = 0; acc_dead0 = 0;
      repeat (c_PERIOD) tick();
   endtask

   task automatic align();
      while (m_pos != c_PERIOD - 1) tick();
   endtask

   initial begin
      RST = 1'b1;
      MC1 = 5'b00001;
      MC2 = 5'b00001;
      repeat (3) tick();
      check("reset_outputs", {R_EN, R_INA, R_INB, L_EN, L_INA, L_INB, PERIOD_TICK, DEAD_ACT}, 9'd0);
      RST = 1'b0;

      MC1 = 5'b10000;
      align();
      period();
      check("fwd4_en_cycles", acc_ren, c_FWD4);
      check("fwd4_left_idle", acc_len, 0);

      for (int c = 0; c < 8; c++) begin
         MC2 = {c[2:0], 2'b00};
         period();
         check("sweep_en_cycles", acc_len, sweep_exp[c]);
      end

      MC1 = 5'b11100;
      period();
      check("fwd7_en_cycles", acc_ren, c_FWD7);
      repeat (5) tick();
      MC1 = 5'b11110;
      align();
      period();
      d1 = acc_dead0;
      check("dead_no_drive", acc_ren, 0);
      period();
      d2 = acc_dead0;
      check("dead_len", d1 + d2, 2 * c_PERIOD);
      period();
      check("rev_after_dead", acc_ren, c_REV7);
      check("rev_inb", {R_INA, R_INB}, 2'b01);

      MC1 = 5'b11111;
      period();
      check("neutral11_en", acc_ren, 0);
      MC1 = 5'b10010;
      period();
      MC1 = 5'b10001;
      period();
      check("neutral01_en", acc_ren, 0);

      MC1 = 5'b00000;
      period();
      check("ramp_step0", acc_ren, ramp_exp[0]);
      MC1 = 5'b11000;
      for (int k = 1; k < 8; k++) begin
         period();
         check("ramp_step", acc_ren, ramp_exp[k]);
      end

      for (int r = 0; r < 40; r++) begin
         repeat ($urandom_range(1, 24)) tick();
         MC1 = 5'($urandom);
         MC2 = 5'($urandom);
      end

      MC1 = 5'b01100;
      MC2 = 5'b00001;
      align();
      period();
      period();
      MC1 = 5'b01110;
      period();
      check("in_dead", DEAD_ACT[0], 1'b1);
      repeat (3) tick();
      RST = 1'b1;
      tick();
      check("rst_in_dead", {R_EN, R_INA, R_INB, L_EN, L_INA, L_INB, PERIOD_TICK, DEAD_ACT}, 9'd0);
      RST = 1'b0;
      acc_ren = 0; acc_dead0 = 0;
      repeat (c_PERIOD - 1) tick();
      check("post_rst_idle_en", acc_ren, 0);
      check("post_rst_no_dead", acc_dead0, 0);
      tick();
      check("post_rst_drive", {R_EN, R_INA, R_INB}, 3'b101);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
